// File: rtl/generic_sram_line_en_initiator.sv
// Initiator end of the generic_sram_line_en interface: valid/ready line commands in,
// single-port SRAM cycles out, read data back through a bypassable response FIFO.
module generic_sram_line_en_initiator #(
    parameter int unsigned MEM_ADDR_BITS = 10,
    parameter int unsigned MEM_DATA_BITS = 32,
    parameter int unsigned RSP_DEPTH     = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic                     i_cmd_write,
    input  logic [MEM_ADDR_BITS-1:0] i_cmd_addr,
    input  logic [MEM_DATA_BITS-1:0] i_cmd_wdata,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [MEM_DATA_BITS-1:0] o_rsp_rdata,
    output logic [MEM_ADDR_BITS-1:0] o_sram_addr,
    output logic                     o_sram_write_en,
    output logic [MEM_DATA_BITS-1:0] o_sram_wdata,
    input  logic [MEM_DATA_BITS-1:0] i_sram_rdata,
    output logic                     o_busy
);

    localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;

    logic                     r_rd_pending;
    logic [CNT_W-1:0]         r_count;
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [MEM_DATA_BITS-1:0] r_mem [RSP_DEPTH];

    logic                     w_rd_pending_nxt;
    logic [CNT_W-1:0]         w_count_nxt;
    logic [PTR_W-1:0]         w_wr_ptr_nxt;
    logic [PTR_W-1:0]         w_rd_ptr_nxt;
    logic [OCC_W-1:0]         w_occupancy;
    logic                     w_credit;
    logic                     w_cmd_fire;
    logic                     w_rd_fire;
    logic                     w_fifo_empty;
    logic                     w_push;
    logic                     w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Credit counts buffered entries plus the read whose data is still on the SRAM bus.
    assign w_occupancy = OCC_W'(r_count) + OCC_W'(r_rd_pending);
    assign w_credit    = w_occupancy < OCC_W'(RSP_DEPTH);
    assign o_cmd_ready = i_rstn & w_credit;

    assign w_cmd_fire      = i_cmd_valid & o_cmd_ready;
    assign w_rd_fire       = w_cmd_fire & ~i_cmd_write;
    assign o_sram_addr     = i_cmd_addr;
    assign o_sram_wdata    = i_cmd_wdata;
    assign o_sram_write_en = w_cmd_fire & i_cmd_write;

    // Empty FIFO forwards the SRAM data directly so a read can respond one cycle after issue.
    assign w_fifo_empty = (r_count == '0);
    assign o_rsp_valid  = r_rd_pending | ~w_fifo_empty;
    assign o_rsp_rdata  = w_fifo_empty ? i_sram_rdata : r_mem[r_rd_ptr];
    assign o_busy       = r_rd_pending | ~w_fifo_empty;

    assign w_push = r_rd_pending & ~(w_fifo_empty & i_rsp_ready);
    assign w_pop  = ~w_fifo_empty & i_rsp_ready;

    always_comb begin
        w_rd_pending_nxt = w_rd_fire;
        w_count_nxt      = r_count;
        w_wr_ptr_nxt     = r_wr_ptr;
        w_rd_ptr_nxt     = r_rd_ptr;
        if (w_push) begin
            w_wr_ptr_nxt = ptr_inc(r_wr_ptr);
        end
        if (w_pop) begin
            w_rd_ptr_nxt = ptr_inc(r_rd_ptr);
        end
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_rd_pending <= 1'b0;
            r_count      <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
        end else begin
            r_rd_pending <= w_rd_pending_nxt;
            r_count      <= w_count_nxt;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_rd_ptr     <= w_rd_ptr_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_sram_rdata;
        end
    end

    // Credit must make a push into a full FIFO impossible.
    always @(posedge i_clk) begin
        if (i_rstn) begin
            assert (!(w_push && (r_count == CNT_W'(RSP_DEPTH))));
        end
    end

endmodule

// File: tb/tb_generic_sram_line_en_initiator.sv
// Directed and random checks of generic_sram_line_en_initiator against a behavioural SRAM
// and reference memory; a second instance covers RSP_DEPTH=4.
`timescale 1ns/1ps
module tb_generic_sram_line_en_initiator;

    logic        clk;
    logic        rstn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [9:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [9:0]  sram_addr;
    logic        sram_we;
    logic [31:0] sram_wdata, sram_rdata;
    logic        busy;

    logic        c4_valid, c4_ready, c4_write;
    logic [9:0]  c4_addr;
    logic [31:0] c4_wdata;
    logic        c4_rsp_valid, c4_rsp_ready;
    logic [31:0] c4_rdata;
    logic [9:0]  c4_sram_addr;
    logic        c4_we;
    logic [31:0] c4_sram_wdata, c4_sram_rdata;
    logic        c4_busy;

    logic [31:0] sram_mem [1024];
    logic [31:0] ref_mem [16];
    logic [31:0] exp_q [$];

    int n_checks = 0;
    int n_errors = 0;

    generic_sram_line_en_initiator #(.MEM_ADDR_BITS(10), .MEM_DATA_BITS(32), .RSP_DEPTH(2)) u_dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
        .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
        .o_sram_addr(sram_addr), .o_sram_write_en(sram_we), .o_sram_wdata(sram_wdata),
        .i_sram_rdata(sram_rdata), .o_busy(busy)
    );

    generic_sram_line_en_initiator #(.MEM_ADDR_BITS(10), .MEM_DATA_BITS(32), .RSP_DEPTH(4)) u_dut4 (
        .i_clk(clk), .i_rstn(rstn),
        .i_cmd_valid(c4_valid), .o_cmd_ready(c4_ready), .i_cmd_write(c4_write),
        .i_cmd_addr(c4_addr), .i_cmd_wdata(c4_wdata),
        .o_rsp_valid(c4_rsp_valid), .i_rsp_ready(c4_rsp_ready), .o_rsp_rdata(c4_rdata),
        .o_sram_addr(c4_sram_addr), .o_sram_write_en(c4_we), .o_sram_wdata(c4_sram_wdata),
        .i_sram_rdata(c4_sram_rdata), .o_busy(c4_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port SRAM, read data one cycle after the address.
    always @(posedge clk) begin
        if (sram_we) sram_mem[sram_addr] <= sram_wdata;
        sram_rdata <= sram_mem[sram_addr];
    end

    // Second instance's SRAM returns the read address as data.
    always @(posedge clk) c4_sram_rdata <= 32'(c4_sram_addr);

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_wdata = d;
        #1;
        chk("wr_ready", 32'(cmd_ready), 1);
        chk("wr_we", 32'(sram_we), 1);
        chk("wr_sram_addr", 32'(sram_addr), 32'(a));
        tick();
        cmd_valid = 1'b0; cmd_write = 1'b0;
    endtask

    initial begin
        int acc;
        int got;
        logic have;

        rstn = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b1;
        c4_valid = 1'b0; c4_write = 1'b0; c4_addr = '0; c4_wdata = 32'h1234; c4_rsp_ready = 1'b0;
        #2;
        chk("rst_ready", 32'(cmd_ready), 0);
        chk("rst_we", 32'(sram_we), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        tick(); tick();
        rstn = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
        #1;
        chk("post_rst_ready", 32'(cmd_ready), 1);
        chk("post_rst_valid", 32'(rsp_valid), 0);
        tick();

        // Write then read the same line; response exactly one cycle after acceptance.
        wr(10'h005, 32'hDEAD_BEEF);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'h005;
        #1;
        chk("t1_rd_ready", 32'(cmd_ready), 1);
        chk("t1_valid_early", 32'(rsp_valid), 0);
        chk("t1_rd_no_we", 32'(sram_we), 0);
        tick();
        cmd_valid = 1'b0;
        #1;
        chk("t1_rsp_valid", 32'(rsp_valid), 1);
        chk("t1_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk("t1_busy", 32'(busy), 1);
        tick();
        #1;
        chk("t1_idle", 32'(rsp_valid), 0);

        // Back-to-back reads at full throughput.
        for (int a = 0; a < 4; a++) wr(10'(a), 32'h100 + 32'(a));
        for (int k = 0; k < 4; k++) begin
            cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'(k);
            #1;
            chk("t2_ready", 32'(cmd_ready), 1);
            if (k > 0) begin
                chk("t2_valid", 32'(rsp_valid), 1);
                chk("t2_rdata", rsp_rdata, 32'h100 + 32'(k - 1));
            end
            tick();
        end
        cmd_valid = 1'b0;
        #1;
        chk("t2_last_rdata", rsp_rdata, 32'h103);
        tick();
        #1;
        chk("t2_idle", 32'(rsp_valid), 0);

        // Backpressure: two reads accepted, then credit runs out.
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'd0;
        #1;
        chk("t3_ready0", 32'(cmd_ready), 1);
        tick();
        cmd_addr = 10'd1;
        #1;
        chk("t3_ready1", 32'(cmd_ready), 1);
        chk("t3_bypass_data", rsp_rdata, 32'h100);
        tick();
        cmd_addr = 10'd2;
        for (int h = 0; h < 5; h++) begin
            #1;
            chk("t3_hold_ready", 32'(cmd_ready), 0);
            chk("t3_hold_valid", 32'(rsp_valid), 1);
            chk("t3_hold_rdata", rsp_rdata, 32'h100);
            tick();
        end
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        #1;
        chk("t3_drain0", rsp_rdata, 32'h100);
        chk("t3_drain0_ready", 32'(cmd_ready), 0);
        tick();
        #1;
        chk("t3_drain1_valid", 32'(rsp_valid), 1);
        chk("t3_drain1", rsp_rdata, 32'h101);
        chk("t3_ready_back", 32'(cmd_ready), 1);
        tick();
        #1;
        chk("t3_empty", 32'(rsp_valid), 0);

        // Top address.
        wr(10'h3FF, 32'hA5A5_5A5A);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'h3FF;
        tick();
        cmd_valid = 1'b0;
        #1;
        chk("t4_top_valid", 32'(rsp_valid), 1);
        chk("t4_top_rdata", rsp_rdata, 32'hA5A5_5A5A);
        tick();

        // Reset with two buffered responses.
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'd0;
        tick();
        cmd_addr = 10'd1;
        tick();
        cmd_write = 1'b1; cmd_addr = 10'd7; cmd_wdata = 32'h55;
        tick();
        #1;
        chk("t5_full_valid", 32'(rsp_valid), 1);
        chk("t5_full_ready", 32'(cmd_ready), 0);
        rstn = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(rsp_valid), 0);
        chk("t5_rst_we", 32'(sram_we), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        tick();
        rstn = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; rsp_ready = 1'b1;
        #1;
        chk("t5_rel_ready", 32'(cmd_ready), 1);
        for (int s = 0; s < 3; s++) begin
            chk("t5_no_stale", 32'(rsp_valid), 0);
            tick();
        end

        // Deeper FIFO: four reads outstanding before credit drops.
        acc = 0;
        c4_rsp_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            c4_valid = 1'b1; c4_addr = 10'(acc);
            #1;
            if (k == 0) chk("d4_no_we", 32'(c4_we), 0);
            if (c4_ready) acc++;
            tick();
        end
        c4_valid = 1'b0;
        #1;
        chk("d4_accepted", 32'(acc), 4);
        chk("d4_full_ready", 32'(c4_ready), 0);
        chk("d4_busy", 32'(c4_busy), 1);
        chk("d4_wdata_pass", c4_sram_wdata, c4_wdata);
        c4_rsp_ready = 1'b1;
        got = 0;
        for (int k = 0; k < 10; k++) begin
            if (c4_rsp_valid) begin
                chk("d4_rdata", c4_rdata, 32'(got));
                got++;
            end
            tick();
        end
        chk("d4_rsp_count", 32'(got), 4);

        // Random mix against a reference memory over lines 0..15.
        for (int a = 0; a < 16; a++) begin
            ref_mem[a] = $urandom;
            wr(10'(a), ref_mem[a]);
        end
        have = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (!have && ($urandom_range(0, 4) != 0)) begin
                have = 1'b1;
                cmd_write = 1'($urandom_range(0, 1));
                cmd_addr = 10'($urandom_range(0, 15));
                cmd_wdata = $urandom;
            end
            cmd_valid = have;
            #1;
            chk("rnd_busy", 32'(busy), 32'(exp_q.size() != 0));
            chk("rnd_credit", 32'(cmd_ready), 32'(exp_q.size() < 2));
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) chk("rnd_extra_rsp", 32'(rsp_valid), 0);
                else chk("rnd_rdata", rsp_rdata, exp_q.pop_front());
            end
            if (have && cmd_ready) begin
                if (cmd_write) ref_mem[cmd_addr[3:0]] = cmd_wdata;
                else exp_q.push_back(ref_mem[cmd_addr[3:0]]);
                have = 1'b0;
            end
            tick();
        end
        rsp_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            cmd_valid = have;
            #1;
            if (rsp_valid) begin
                if (exp_q.size() == 0) chk("drain_extra_rsp", 32'(rsp_valid), 0);
                else chk("drain_rdata", rsp_rdata, exp_q.pop_front());
            end
            if (have && cmd_ready) begin
                if (cmd_write) ref_mem[cmd_addr[3:0]] = cmd_wdata;
                else exp_q.push_back(ref_mem[cmd_addr[3:0]]);
                have = 1'b0;
            end
            tick();
        end
        cmd_valid = 1'b0;
        #1;
        chk("drain_left", 32'(exp_q.size()), 0);
        chk("drain_busy", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
